// File: rtl/xfer_req_arb.sv
// Round-robin arbiter: NUM_CH request FIFOs feed one registered output slot.
// Optional macro XFER_REQ_ARB_ZERO_LEN_DROP_EN: zero-length requests are accepted, counted, discarded.
module xfer_req_arb #(
   parameter int NUM_CH = 4,
   parameter int LEN_W  = 4,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic [NUM_CH-1:0]           in_valid,
   output logic [NUM_CH-1:0]           in_ready,
   input  logic [NUM_CH*LEN_W-1:0]     in_length,
   input  logic [NUM_CH*ADDR_W-1:0]    in_source,
   input  logic [NUM_CH*ADDR_W-1:0]    in_destination,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LEN_W-1:0]            out_length,
   output logic [ADDR_W-1:0]           out_source,
   output logic [ADDR_W-1:0]           out_destination,
   output logic [$clog2(NUM_CH)-1:0]   out_ch,
   output logic [7:0]                  drop_cnt
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int PW   = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
   } entry_t;

   entry_t            mem      [NUM_CH][DEPTH];
   entry_t            in_entry [NUM_CH];
   logic [PW:0]       wr_ptr   [NUM_CH];
   logic [PW:0]       rd_ptr   [NUM_CH];
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] accept;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [CH_W-1:0]   last_grant;
   logic [CH_W-1:0]   winner;
   logic              found;
   logic              load;
   entry_t            head;

   // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         in_entry[i] = {in_length[i*LEN_W +: LEN_W],
                        in_source[i*ADDR_W +: ADDR_W],
                        in_destination[i*ADDR_W +: ADDR_W]};
         empty[i]    = (wr_ptr[i] == rd_ptr[i]);
         full[i]     = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                       (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
      end
   end

   // Ready depends on stored occupancy only, so a full FIFO refuses even while being popped.
   assign in_ready = ~full;
   assign accept   = in_valid & in_ready;
   assign load     = !out_valid || out_ready;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!found && !empty[CH_W'((int'(last_grant) + k) % NUM_CH)]) begin
            found  = 1'b1;
            winner = CH_W'((int'(last_grant) + k) % NUM_CH);
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = load && found && (winner == CH_W'(i));
      end
   end

   assign head = mem[winner][rd_ptr[winner][PW-1:0]];

`ifdef XFER_REQ_ARB_ZERO_LEN_DROP_EN
   logic [NUM_CH-1:0] zero_len;
   logic [3:0]        drop_num;
   logic [8:0]        drop_sum;

   always_comb begin
      zero_len = '0;
      drop_num = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         zero_len[i] = (in_length[i*LEN_W +: LEN_W] == '0);
         drop_num    = drop_num + 4'(accept[i] & zero_len[i]);
      end
   end

   assign push     = accept & ~zero_len;
   assign drop_sum = {1'b0, drop_cnt} + 9'(drop_num);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         drop_cnt <= '0;
      else if (drop_sum > 9'd255)
         drop_cnt <= 8'hFF;
      else
         drop_cnt <= drop_sum[7:0];
   end
`else
   assign push     = accept;
   assign drop_cnt = 8'd0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
         end
      end
   end

   // NOTE: storage is not reset; clearing the pointers makes any stale entry unreachable.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) mem[i][wr_ptr[i][PW-1:0]] <= in_entry[i];
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_valid       <= 1'b0;
         out_length      <= '0;
         out_source      <= '0;
         out_destination <= '0;
         out_ch          <= '0;
         last_grant      <= CH_W'(NUM_CH - 1);
      end else if (load) begin
         out_valid <= found;
         if (found) begin
            out_length      <= head.len;
            out_source      <= head.src;
            out_destination <= head.dst;
            out_ch          <= winner;
            last_grant      <= winner;
         end
      end
   end

endmodule

// File: tb/tb_xfer_req_arb.sv
// Bench for xfer_req_arb: queue-based reference model checked every cycle, plus directed scenarios
// with literal expectations. Honours XFER_REQ_ARB_ZERO_LEN_DROP_EN when defined.
module tb_xfer_req_arb;
   localparam int NUM_CH = 4;
   localparam int LEN_W  = 4;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int W      = LEN_W + 2*ADDR_W;
`ifdef XFER_REQ_ARB_ZERO_LEN_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       nrst;
   logic [NUM_CH-1:0]          in_valid;
   logic [NUM_CH-1:0]          in_ready;
   logic [NUM_CH*LEN_W-1:0]    in_length;
   logic [NUM_CH*ADDR_W-1:0]   in_source;
   logic [NUM_CH*ADDR_W-1:0]   in_destination;
   logic                       out_valid;
   logic                       out_ready;
   logic [LEN_W-1:0]           out_length;
   logic [ADDR_W-1:0]          out_source;
   logic [ADDR_W-1:0]          out_destination;
   logic [CH_W-1:0]            out_ch;
   logic [7:0]                 drop_cnt;

   xfer_req_arb #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready), .in_length(in_length),
      .in_source(in_source), .in_destination(in_destination),
      .out_valid(out_valid), .out_ready(out_ready), .out_length(out_length),
      .out_source(out_source), .out_destination(out_destination),
      .out_ch(out_ch), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: per-channel queues, one output slot, round-robin pointer.
   logic [W-1:0] mq [NUM_CH][$];
   logic         m_ov   = 1'b0;
   logic [W-1:0] m_out  = '0;
   int           m_ch   = 0;
   int           m_last = NUM_CH - 1;
   int           m_drop = 0;
   int           m_w;
   bit           m_acc [NUM_CH];

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NUM_CH; i++) mq[i].delete();
         m_ov = 1'b0; m_out = '0; m_ch = 0; m_last = NUM_CH - 1; m_drop = 0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) m_acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
         if (!m_ov || out_ready) begin
            m_w = -1;
            for (int k = 1; k <= NUM_CH; k++)
               if (m_w < 0 && mq[(m_last + k) % NUM_CH].size() > 0) m_w = (m_last + k) % NUM_CH;
            if (m_w >= 0) begin
               m_out = mq[m_w].pop_front(); m_ch = m_w; m_last = m_w; m_ov = 1'b1;
            end else begin
               m_ov = 1'b0;
            end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (m_acc[i]) begin
               if (DROP_EN && in_length[i*LEN_W +: LEN_W] == 0) begin
                  if (m_drop < 255) m_drop++;
               end else begin
                  mq[i].push_back({in_length[i*LEN_W +: LEN_W], in_source[i*ADDR_W +: ADDR_W],
                                   in_destination[i*ADDR_W +: ADDR_W]});
               end
            end
         end
      end
   end

   int gl_ch [$];
   int gl_len [$];
   int zg = 0;

   always @(negedge clk) begin
      if (nrst) begin
         for (int i = 0; i < NUM_CH; i++) check("in_ready", in_ready[i], 32'(mq[i].size() < DEPTH));
         check("out_valid", out_valid, m_ov);
         if (m_ov) begin
            check("out_ch", out_ch, m_ch);
            check("out_length", out_length, m_out[W-1 -: LEN_W]);
            check("out_source", out_source, m_out[2*ADDR_W-1 -: ADDR_W]);
            check("out_destination", out_destination, m_out[ADDR_W-1:0]);
         end
         check("drop_cnt", drop_cnt, m_drop);
         if (out_valid && out_ready) begin
            gl_ch.push_back(int'(out_ch));
            gl_len.push_back(int'(out_length));
            if (out_ch == 0 && out_length == 0) zg++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ch(input int i, input logic [LEN_W-1:0] len,
                         input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
      in_length[i*LEN_W +: LEN_W]        = len;
      in_source[i*ADDR_W +: ADDR_W]      = src;
      in_destination[i*ADDR_W +: ADDR_W] = dst;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_out_length", out_length, 0);
      check("rst_out_source", out_source, 0);
      check("rst_out_destination", out_destination, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_in_ready", in_ready, 4'hF);
      tick();
      nrst = 1'b1;
   endtask

   int acc;
   bit got5;

   initial begin
      nrst = 1'b1; in_valid = '0; in_length = '0; in_source = '0; in_destination = '0;
      out_ready = 1'b1;
      #3;
      do_reset();

      // Single request on ch2: one cycle of latency, then the slot empties.
      set_ch(2, 3, 8'h11, 8'h22); in_valid = 4'b0100;
      tick(); in_valid = '0;
      check("s1_not_early", out_valid, 0);
      tick();
      check("s1_valid", out_valid, 1);
      check("s1_ch", out_ch, 2);
      check("s1_len", out_length, 3);
      check("s1_src", out_source, 8'h11);
      check("s1_dst", out_destination, 8'h22);
      tick();
      check("s1_idle", out_valid, 0);

      // All four channels at once after reset: grants 0,1,2,3.
      do_reset();
      gl_ch.delete(); gl_len.delete();
      for (int i = 0; i < NUM_CH; i++) set_ch(i, LEN_W'(i + 1), 8'(16*i + 1), 8'(16*i + 2));
      in_valid = 4'b1111;
      tick(); in_valid = '0;
      repeat (6) tick();
      check("s2_count", gl_ch.size(), 4);
      for (int k = 0; k < 4; k++) check("s2_order", k < gl_ch.size() ? gl_ch[k] : 99, k);

      // ch1 fills behind an occupied slot: 4 accepted, 5th held until space frees.
      gl_ch.delete(); gl_len.delete();
      out_ready = 1'b0;
      set_ch(0, 7, 8'h70, 8'h71); in_valid = 4'b0001;
      tick(); in_valid = '0;
      tick();
      for (int j = 1; j <= 4; j++) begin
         set_ch(1, LEN_W'(j), 8'(8'h10 + j), 8'(8'h20 + j)); in_valid = 4'b0010;
         tick();
      end
      set_ch(1, 5, 8'h15, 8'h25);
      tick();
      check("s3_full", in_ready[1], 0);
      check("s3_hold_ch", out_ch, 0);
      check("s3_hold_len", out_length, 7);
      out_ready = 1'b1;
      got5 = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (in_ready[1]) begin
            tick(); got5 = 1'b1; break;
         end
         tick();
      end
      in_valid = '0;
      check("s3_fifth_accepted", got5, 1);
      repeat (8) tick();
      check("s3_count", gl_ch.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check("s3_ch", k < gl_ch.size() ? gl_ch[k] : 99, k == 0 ? 0 : 1);
         check("s3_len", k < gl_len.size() ? gl_len[k] : 99, k == 0 ? 7 : k);
      end

      // Stalled output holds while ch0 and ch2 keep pushing.
      out_ready = 1'b0;
      set_ch(3, 9, 8'h33, 8'h44); in_valid = 4'b1000;
      tick(); in_valid = '0;
      tick();
      for (int t = 0; t < 3; t++) begin
         set_ch(0, LEN_W'(t + 1), 8'h01, 8'h02);
         set_ch(2, LEN_W'(t + 4), 8'h03, 8'h04);
         in_valid = 4'b0101;
         tick();
         check("s4_valid", out_valid, 1);
         check("s4_ch", out_ch, 3);
         check("s4_len", out_length, 9);
         check("s4_src", out_source, 8'h33);
         check("s4_dst", out_destination, 8'h44);
      end
      in_valid = '0;
      gl_ch.delete(); gl_len.delete();
      out_ready = 1'b1;
      repeat (10) tick();
      check("s4_count", gl_ch.size(), 7);
      for (int k = 0; k < 7; k++) begin
         int ech [7] = '{3, 0, 2, 0, 2, 0, 2};
         int eln [7] = '{9, 1, 4, 2, 5, 3, 6};
         check("s4_ch", k < gl_ch.size() ? gl_ch[k] : 99, ech[k]);
         check("s4_len", k < gl_len.size() ? gl_len[k] : 99, eln[k]);
      end

      // Reset mid-transfer with 3 queued and the slot full; afterwards first pusher wins.
      out_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) set_ch(i, LEN_W'(i + 1), 8'hA0, 8'hB0);
      in_valid = 4'b1111;
      tick(); in_valid = '0;
      tick();
      check("s5_pre_valid", out_valid, 1);
      do_reset();
      gl_ch.delete(); gl_len.delete();
      out_ready = 1'b1;
      set_ch(2, 6, 8'h66, 8'h67); in_valid = 4'b0100;
      tick();
      set_ch(0, 5, 8'h55, 8'h56); in_valid = 4'b0001;
      tick(); in_valid = '0;
      repeat (5) tick();
      check("s5_count", gl_ch.size(), 2);
      check("s5_first", gl_ch.size() > 0 ? gl_ch[0] : 99, 2);
      check("s5_second", gl_ch.size() > 1 ? gl_ch[1] : 99, 0);

      // 300 zero-length requests on ch0.
      zg = 0; acc = 0;
      set_ch(0, 0, 8'h55, 8'h66); in_valid = 4'b0001;
      for (int n = 0; n < 400 && acc < 300; n++) begin
         if (in_ready[0]) acc++;
         tick();
      end
      in_valid = '0;
      repeat (5) tick();
      check("s6_accepted", acc, 300);
      check("s6_granted", zg, DROP_EN ? 0 : 300);
      check("s6_drop_cnt", drop_cnt, DROP_EN ? 255 : 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
